alif_sel_seq: RTL and testbench
===============================

Name: alif_sel_seq

Overview:
- Upstream stimulus/check stage for the two-select if/else mux block, which outputs b when sel_b1 && sel_b2 and a otherwise.
- On a start pulse, steps through all four select combinations for two data phases: a/b as sampled, then a/b inverted.
- Holds each combination for HOLD_CYCLES clocks and compares the mux's returned output against the expected value.
- Counts mismatches and pulses done when finished.

Parameters:
HOLD_CYCLES, 5, clocks each select combination is held (legal range 1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
areset  input  1  asynchronous active-high reset
start  input  1  request a run; accepted only in IDLE
stop  input  1  synchronous abort; returns to IDLE without done
a_in  input  1  value for mux input a, sampled on accepted start
b_in  input  1  value for mux input b, sampled on accepted start
mux_out  input  1  output returned from the mux under test (combinational path from a/b/sel_*)
a  output  1  drives mux input a
b  output  1  drives mux input b
sel_b1  output  1  drives mux sel_b1
sel_b2  output  1  drives mux sel_b2
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a run completes normally
step  output  3  current step index 0..7
err_cnt  output  4  mismatch count of current/last run, saturating at 15

Behaviour:
- Interface: one clock, clk; reset areset is asynchronous and active-high. On areset, all outputs are 0 and the state is IDLE.
- States and transitions:
  - IDLE: start=1 and stop=0 -> RUN.
  - RUN: stop=1 -> IDLE. After the last cycle of step 7 -> IDLE with done pulse.
- Start acceptance (edge T with start=1 in IDLE):
  - Latch a_in/b_in.
  - Clear err_cnt and the hold counter; set step=0.
  - From T+1: busy=1.
- Step encoding, step[1:0] -> {sel_b2,sel_b1}:
  - 0 -> 00, 1 -> 01, 2 -> 10, 3 -> 11, i.e. sel_b1 = step[0], sel_b2 = step[1].
  - step[2]=0: a = latched a_in, b = latched b_in.
  - step[2]=1: a = ~latched a_in, b = ~latched b_in.
- All of a, b, sel_b1, sel_b2 and step are registered outputs.
- Hold counter runs 0..HOLD_CYCLES-1 within each step. At HOLD_CYCLES-1 the next edge advances step and clears the counter.
- Check: exactly once per step, on the edge ending the step's last cycle, mux_out is compared with expected = (sel_b1 & sel_b2) ? b : a.
  - Mismatch -> err_cnt+1, saturating at 15.
  - Earlier cycles within a step are not checked (settle time).
- Run length: busy is high for exactly 8*HOLD_CYCLES cycles.
- Completion: on the edge ending step 7:
  - state -> IDLE, busy=0, done=1 for one cycle.
  - a, b, sel_b1, sel_b2, step -> 0.
  - err_cnt, including the step-7 check, holds its value until the next accepted start or reset.
- stop in RUN:
  - Next edge: IDLE, busy=0, done=0, a/b/sel/step -> 0.
  - err_cnt keeps its partial count; the in-progress step is not checked.
- Simultaneous events:
  - start and stop together in IDLE: stop wins, no run.
  - start while busy: ignored, no restart.
  - start in the same cycle done is high: accepted, because the state is already IDLE.
- areset mid-run: immediate return to IDLE, all outputs 0, no done.
- HOLD_CYCLES=1: each step lasts one cycle and is checked every edge.

Test Plan:
- Reset mid-run: HOLD=5, start at cycle 0, assert areset at cycle 13 -> all outputs 0 immediately, no done; a subsequent start runs normally.
- Correct mux wired to mux_out, HOLD=5, a_in=0, b_in=1, start -> sel sequence 00,01,10,11 then repeated with a=1/b=0, each held 5 cycles. busy high 40 cycles, done pulses once, err_cnt=0.
- mux_out tied 0, a_in=0, b_in=1 -> expected values 0,0,0,1,1,1,1,0, so err_cnt=4 at done. Tied 1 -> err_cnt=4.
- Abort and re-start while busy:
  - stop asserted during step 3 -> busy drops next edge, done never pulses, err_cnt holds its partial value.
  - start pulsed during step 2 -> ignored; step continues to 7 and done occurs at the original time.
- HOLD=1, correct mux, a_in=1, b_in=1 -> step changes every cycle, busy high 8 cycles, err_cnt=0. Back-to-back start in the done cycle -> second run starts with err_cnt cleared.

Source files
------------

// File: rtl/alif_sel_seq_if.sv
// Handshake bundle between the select-sequencer stage and its driver/mux side.
// The slave modport is the sequencer's view; master is the driving side.
interface alif_sel_seq_if;
   logic       start;
   logic       stop;
   logic       a_in;
   logic       b_in;
   logic       mux_out;
   logic       a;
   logic       b;
   logic       sel_b1;
   logic       sel_b2;
   logic       busy;
   logic       done;
   logic [2:0] step;
   logic [3:0] err_cnt;

   modport master (
      output start, stop, a_in, b_in, mux_out,
      input  a, b, sel_b1, sel_b2, busy, done, step, err_cnt
   );

   modport slave (
      input  start, stop, a_in, b_in, mux_out,
      output a, b, sel_b1, sel_b2, busy, done, step, err_cnt
   );
endinterface

// File: rtl/alif_sel_seq.sv
// Stimulus/check sequencer for the two-select mux (b when sel_b1 && sel_b2,
// a otherwise). A run walks the four select codes twice, first with the
// sampled a/b and then inverted, holds each code HOLD_CYCLES clocks and
// compares the returned mux output once at the end of every step.
module alif_sel_seq #(
   parameter int unsigned HOLD_CYCLES = 5   // 1..255
) (
   input logic          clk,
   input logic          areset,
   alif_sel_seq_if.slave bus
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     r_state, w_state_nxt;
   logic       r_a_lat, w_a_lat_nxt;
   logic       r_b_lat, w_b_lat_nxt;
   logic [7:0] r_hold,  w_hold_nxt;
   logic [2:0] r_step,  w_step_nxt;
   logic [3:0] r_err,   w_err_nxt;
   logic       r_done,  w_done_nxt;
   logic       r_a, r_b, r_sel_b1, r_sel_b2, r_busy;
   logic       w_run_nxt;
   logic       w_expected;

   // State register.
   // NOTE: clocked blocks use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state, step/hold sequencing and end-of-step mux check.
   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      w_state_nxt = r_state;
      w_a_lat_nxt = r_a_lat;
      w_b_lat_nxt = r_b_lat;
      w_hold_nxt  = r_hold;
      w_step_nxt  = r_step;
      w_err_nxt   = r_err;
      w_done_nxt  = 1'b0;
      // Expected value uses the registered drive currently seen by the mux.
      w_expected  = (r_sel_b1 & r_sel_b2) ? r_b : r_a;

      case (r_state)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               w_state_nxt = ST_RUN;
               w_a_lat_nxt = bus.a_in;
               w_b_lat_nxt = bus.b_in;
               w_hold_nxt  = '0;
               w_step_nxt  = '0;
               w_err_nxt   = '0;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               // Abort: the in-progress step is not checked.
               w_state_nxt = ST_IDLE;
               w_hold_nxt  = '0;
               w_step_nxt  = '0;
            end else if (r_hold == HOLD_LAST) begin
               if ((bus.mux_out != w_expected) && (r_err != 4'hF))
                  w_err_nxt = r_err + 4'd1;
               w_hold_nxt = '0;
               if (r_step == 3'd7) begin
                  w_state_nxt = ST_IDLE;
                  w_step_nxt  = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_step_nxt = r_step + 3'd1;
               end
            end else begin
               w_hold_nxt = r_hold + 8'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_run_nxt = (w_state_nxt == ST_RUN);
   end

   // Datapath registers; mux drive is decoded from the next step so it is
   // registered alongside it and drops to zero whenever the run ends.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_a_lat  <= 1'b0;
         r_b_lat  <= 1'b0;
         r_hold   <= '0;
         r_step   <= '0;
         r_err    <= '0;
         r_done   <= 1'b0;
         r_a      <= 1'b0;
         r_b      <= 1'b0;
         r_sel_b1 <= 1'b0;
         r_sel_b2 <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_a_lat  <= w_a_lat_nxt;
         r_b_lat  <= w_b_lat_nxt;
         r_hold   <= w_hold_nxt;
         r_step   <= w_step_nxt;
         r_err    <= w_err_nxt;
         r_done   <= w_done_nxt;
         r_a      <= w_run_nxt & (w_a_lat_nxt ^ w_step_nxt[2]);
         r_b      <= w_run_nxt & (w_b_lat_nxt ^ w_step_nxt[2]);
         r_sel_b1 <= w_run_nxt & w_step_nxt[0];
         r_sel_b2 <= w_run_nxt & w_step_nxt[1];
         r_busy   <= w_run_nxt;
      end
   end

   assign bus.a       = r_a;
   assign bus.b       = r_b;
   assign bus.sel_b1  = r_sel_b1;
   assign bus.sel_b2  = r_sel_b2;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.step    = r_step;
   assign bus.err_cnt = r_err;

endmodule

// File: tb/tb_alif_sel_seq.sv
// Bench for alif_sel_seq: two instances (HOLD_CYCLES 5 and 1) each closing
// the loop through a mux model that can be correct or stuck at 0/1.
module tb_alif_sel_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       areset;
   logic       use1;      // 1: drive/observe the HOLD=1 instance
   logic       start_r, stop_r, a_in_r, b_in_r;
   logic [1:0] mode;      // 0 correct mux, 1 stuck 0, 2 stuck 1

   alif_sel_seq_if if5 ();
   alif_sel_seq_if if1 ();

   alif_sel_seq #(.HOLD_CYCLES(5)) dut5 (.clk(clk), .areset(areset), .bus(if5.slave));
   alif_sel_seq #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .areset(areset), .bus(if1.slave));

   function automatic logic mux_model(input logic [1:0] m, input logic a, input logic b,
                                      input logic s1, input logic s2);
      if (m == 2'd1) return 1'b0;
      if (m == 2'd2) return 1'b1;
      return (s1 && s2) ? b : a;
   endfunction

   assign if5.start   = start_r & ~use1;
   assign if5.stop    = stop_r & ~use1;
   assign if5.a_in    = a_in_r;
   assign if5.b_in    = b_in_r;
   assign if5.mux_out = mux_model(mode, if5.a, if5.b, if5.sel_b1, if5.sel_b2);
   assign if1.start   = start_r & use1;
   assign if1.stop    = stop_r & use1;
   assign if1.a_in    = a_in_r;
   assign if1.b_in    = b_in_r;
   assign if1.mux_out = mux_model(mode, if1.a, if1.b, if1.sel_b1, if1.sel_b2);

   logic [6:0] cur_vec;   // {step, a, b, sel_b2, sel_b1}
   logic       cur_busy, cur_done;
   logic [3:0] cur_err;
   assign cur_vec  = use1 ? {if1.step, if1.a, if1.b, if1.sel_b2, if1.sel_b1}
                          : {if5.step, if5.a, if5.b, if5.sel_b2, if5.sel_b1};
   assign cur_busy = use1 ? if1.busy : if5.busy;
   assign cur_done = use1 ? if1.done : if5.done;
   assign cur_err  = use1 ? if1.err_cnt : if5.err_cnt;

   typedef struct packed {
      logic [2:0] step;
      logic       a;
      logic       b;
      logic       s2;
      logic       s1;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Expected error count after the first nsteps checked steps.
   function automatic int model_err(input logic ai, input logic bi, input logic [1:0] m,
                                    input int nsteps);
      int e = 0;
      for (int s = 0; s < nsteps; s++) begin
         logic sa, sb, s1, s2, ex;
         sa = ai ^ s[2];
         sb = bi ^ s[2];
         s1 = s[0];
         s2 = s[1];
         ex = (s1 && s2) ? sb : sa;
         if (mux_model(m, sa, sb, s1, s2) != ex && e < 15) e++;
      end
      return e;
   endfunction

   task automatic push_run(input logic ai, input logic bi, input int hold);
      exp_t e;
      for (int s = 0; s < 8; s++) begin
         for (int h = 0; h < hold; h++) begin
            e.step = 3'(s);
            e.a    = ai ^ s[2];
            e.b    = bi ^ s[2];
            e.s1   = s[0];
            e.s2   = s[1];
            q.push_back(e);
         end
      end
   endtask

   // Start a run at the current negedge; returns at the first busy cycle.
   task automatic launch(input logic ai, input logic bi);
      a_in_r  = ai;
      b_in_r  = bi;
      start_r = 1'b1;
      push_run(ai, bi, use1 ? 1 : 5);
      @(negedge clk);
      start_r = 1'b0;
      a_in_r  = ~ai;   // must not affect the latched values
      b_in_r  = ~bi;
   endtask

   // Observe n cycles: pop/compare drive while busy, count done pulses.
   task automatic monitor(input int n, input int start_at, output int busy_cyc,
                          output int done_cnt, output int done_at);
      busy_cyc = 0;
      done_cnt = 0;
      done_at  = -1;
      for (int i = 0; i < n; i++) begin
         if (cur_busy) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL busy_extra: busy=1 at cycle %0d, required busy=0", i);
            end else begin
               exp_t e;
               e = q.pop_front();
               n_cmp++;
               if (cur_vec !== e) begin
                  n_err++;
                  $display("FAIL drive cyc%0d: got {step,a,b,s2,s1}=%b required %b", i, cur_vec, e);
               end
            end
            busy_cyc++;
         end
         if (cur_done) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
            n_cmp++;
            if ({cur_busy, cur_vec} !== 8'h00) begin
               n_err++;
               $display("FAIL done_outputs: got {busy,vec}=%b required 0", {cur_busy, cur_vec});
            end
         end
         start_r = (i == start_at);
         @(negedge clk);
      end
      start_r = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({if5.busy, if5.done, if5.step, if5.a, if5.b, if5.sel_b1, if5.sel_b2, if5.err_cnt} !== 13'h0) begin
         n_err++;
         $display("FAIL reset_h5: outputs not zero");
      end
      n_cmp++;
      if ({if1.busy, if1.done, if1.step, if1.a, if1.b, if1.sel_b1, if1.sel_b2, if1.err_cnt} !== 13'h0) begin
         n_err++;
         $display("FAIL reset_h1: outputs not zero");
      end
      areset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int bc, dc, da;
      use1 = 1'b0;
      mode = 2'd0;
      launch(1'b0, 1'b1);
      monitor(13, -1, bc, dc, da);
      n_cmp++;
      if (bc !== 13) begin
         n_err++;
         $display("FAIL midrst_busy: got %0d required 13", bc);
      end
      #2 areset = 1'b1;
      #1;
      n_cmp++;
      if ({if5.busy, if5.done, if5.step, if5.a, if5.b, if5.sel_b1, if5.sel_b2, if5.err_cnt} !== 13'h0) begin
         n_err++;
         $display("FAIL midrst_outputs: not zero immediately after reset");
      end
      @(negedge clk);
      areset = 1'b0;
      q.delete();
      monitor(4, -1, bc, dc, da);
      n_cmp++;
      if ({bc, dc} !== {32'd0, 32'd0}) begin
         n_err++;
         $display("FAIL midrst_quiet: busy %0d done %0d required 0/0", bc, dc);
      end
   endtask

   task automatic test_full_run(input logic [1:0] m, input logic ai, input logic bi,
                                input logic h1, input int start_at);
      int bc, dc, da, hold;
      use1 = h1;
      mode = m;
      hold = h1 ? 1 : 5;
      launch(ai, bi);
      monitor(8 * hold + 3, start_at, bc, dc, da);
      n_cmp++;
      if (bc !== 8 * hold) begin
         n_err++;
         $display("FAIL run_busy m%0d h%0d: got %0d required %0d", m, hold, bc, 8 * hold);
      end
      n_cmp++;
      if (dc !== 1 || da !== 8 * hold) begin
         n_err++;
         $display("FAIL run_done m%0d h%0d: count %0d at %0d required 1 at %0d", m, hold, dc, da, 8 * hold);
      end
      n_cmp++;
      if (cur_err !== 4'(model_err(ai, bi, m, 8))) begin
         n_err++;
         $display("FAIL run_err m%0d h%0d: got %0d required %0d", m, hold, cur_err, model_err(ai, bi, m, 8));
      end
      n_cmp++;
      if (q.size() !== 0) begin
         n_err++;
         $display("FAIL run_left m%0d: %0d expected drive entries unconsumed", m, q.size());
      end
      q.delete();
   endtask

   task automatic test_abort();
      int bc, dc, da;
      use1 = 1'b0;
      mode = 2'd2;
      launch(1'b0, 1'b1);
      monitor(17, -1, bc, dc, da);   // cycle 17 lies inside step 3
      stop_r = 1'b1;
      @(negedge clk);
      stop_r = 1'b0;
      n_cmp++;
      if ({cur_busy, cur_done, cur_vec} !== 9'h0) begin
         n_err++;
         $display("FAIL abort_outputs: got %b required 0", {cur_busy, cur_done, cur_vec});
      end
      n_cmp++;
      if (cur_err !== 4'(model_err(1'b0, 1'b1, 2'd2, 3))) begin
         n_err++;
         $display("FAIL abort_err: got %0d required %0d", cur_err, model_err(1'b0, 1'b1, 2'd2, 3));
      end
      q.delete();
      monitor(6, -1, bc, dc, da);
      n_cmp++;
      if (dc !== 0) begin
         n_err++;
         $display("FAIL abort_done: got %0d pulses required 0", dc);
      end
      start_r = 1'b1;
      stop_r  = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      stop_r  = 1'b0;
      n_cmp++;
      if (cur_busy !== 1'b0) begin
         n_err++;
         $display("FAIL start_stop_idle: busy got %b required 0", cur_busy);
      end
   endtask

   task automatic test_back_to_back();
      int bc, dc, da;
      use1 = 1'b1;
      mode = 2'd1;
      launch(1'b1, 1'b1);
      monitor(8, -1, bc, dc, da);
      n_cmp++;
      if ({cur_done, cur_err} !== {1'b1, 4'(model_err(1'b1, 1'b1, 2'd1, 8))}) begin
         n_err++;
         $display("FAIL b2b_first: done/err got %b/%0d required 1/%0d", cur_done, cur_err,
                  model_err(1'b1, 1'b1, 2'd1, 8));
      end
      mode = 2'd0;
      launch(1'b1, 1'b0);            // start in the done cycle
      n_cmp++;
      if ({cur_busy, cur_err} !== 5'b1_0000) begin
         n_err++;
         $display("FAIL b2b_restart: busy/err got %b/%0d required 1/0", cur_busy, cur_err);
      end
      monitor(11, -1, bc, dc, da);
      n_cmp++;
      if (bc !== 8 || dc !== 1 || cur_err !== 4'd0) begin
         n_err++;
         $display("FAIL b2b_second: busy %0d done %0d err %0d required 8/1/0", bc, dc, cur_err);
      end
      q.delete();
   endtask

   initial begin
      use1    = 1'b0;
      mode    = 2'd0;
      start_r = 1'b0;
      stop_r  = 1'b0;
      a_in_r  = 1'b0;
      b_in_r  = 1'b0;
      test_reset();
      test_reset_mid_run();
      test_full_run(2'd0, 1'b0, 1'b1, 1'b0, -1);   // correct mux, HOLD=5
      test_full_run(2'd1, 1'b0, 1'b1, 1'b0, -1);   // stuck 0
      test_full_run(2'd2, 1'b0, 1'b1, 1'b0, -1);   // stuck 1
      test_abort();
      test_full_run(2'd0, 1'b1, 1'b0, 1'b0, 12);   // start pulsed in step 2
      test_full_run(2'd0, 1'b1, 1'b1, 1'b1, -1);   // HOLD=1
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
